// File: rtl/ucode_sequencer.sv
// Microcode sequencer: writable main/sub step tables, wait-for-ready with
// timeout, conditional sequencing, illegal-sequence detection and instret.
module ucode_sequencer #(
    parameter int OPW = 5,
    parameter int FW = 3,
    parameter int CW = 32,
    parameter int STEPS = 8,
    parameter int TIMEOUT = 16,
    parameter int CNT_W = 64,
    parameter logic [CW+4:0] FETCH_WORD = '0,
    localparam int SW = $clog2(STEPS),
    localparam int TW = $clog2(TIMEOUT) + 1,
    localparam int EW = CW + 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [OPW-1:0]   opcode,
    input  logic [FW-1:0]    func,
    input  logic             ready,
    input  logic             cond,
    input  logic             trap,
    input  logic             prog_en,
    input  logic             prog_sel,
    input  logic [OPW-1:0]   prog_row,
    input  logic [SW-1:0]    prog_step,
    input  logic [EW-1:0]    prog_data,
    output logic [CW-1:0]    ctrl,
    output logic [SW-1:0]    step,
    output logic             fetch,
    output logic             stall,
    output logic             illegal,
    output logic             timeout,
    output logic [CNT_W-1:0] instret
);

    localparam int INC_B  = CW;
    localparam int RST_B  = CW + 1;
    localparam int COND_B = CW + 2;
    localparam int WAIT_B = CW + 3;
    localparam int SUB_B  = CW + 4;
    localparam int MDEPTH = (2 ** OPW) * STEPS;
    localparam int SDEPTH = (2 ** FW) * STEPS;

    typedef logic [EW-1:0] main_tbl_t [MDEPTH];

    function automatic main_tbl_t main_init();
        main_tbl_t t;
        for (int i = 0; i < MDEPTH; i++) begin
            t[i] = (i % STEPS == 0) ? FETCH_WORD : '0;
        end
        return t;
    endfunction

    // Contents persist across reset; only the power-up image is preloaded.
    main_tbl_t main_mem = main_init();
    logic [EW-1:0] sub_mem [SDEPTH] = '{default: '0};

    logic [SW-1:0]    step_q;
    logic [TW-1:0]    wait_cnt;
    logic [CNT_W-1:0] instret_q;
    logic             illegal_q;
    logic             timeout_q;

    logic [EW-1:0] main_e;
    logic [EW-1:0] sub_e;
    logic [EW-1:0] ent;
    logic          e_inc;
    logic          e_rst;
    logic          e_cond;
    logic          e_wait;

    always_comb begin
        main_e = main_mem[{opcode, step_q}];
        sub_e  = sub_mem[{func, step_q}];
        ent    = main_e | (main_e[SUB_B] ? sub_e : '0);
    end

    assign e_inc  = ent[INC_B];
    assign e_rst  = ent[RST_B];
    assign e_cond = ent[COND_B];
    assign e_wait = ent[WAIT_B];

    assign ctrl    = (trap || reset) ? '0 : ent[CW-1:0];
    assign stall   = e_wait && !ready && !trap && !reset;
    assign step    = step_q;
    assign fetch   = (step_q == '0);
    assign illegal = illegal_q;
    assign timeout = timeout_q;
    assign instret = instret_q;

    always_ff @(posedge clk) begin
        if (prog_en) begin
            if (prog_sel) begin
                sub_mem[{prog_row[FW-1:0], prog_step}] <= prog_data;
            end else begin
                main_mem[{prog_row, prog_step}] <= prog_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        illegal_q <= 1'b0;
        timeout_q <= 1'b0;
        if (reset) begin
            step_q    <= '0;
            wait_cnt  <= '0;
            instret_q <= '0;
        end else if (trap) begin
            step_q   <= '0;
            wait_cnt <= '0;
        end else if (e_wait && !ready) begin
            if (wait_cnt == TW'(TIMEOUT - 1)) begin
                step_q    <= '0;
                wait_cnt  <= '0;
                timeout_q <= 1'b1;
            end else begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end else begin
            wait_cnt <= '0;
            if (e_cond) begin
                if (cond) begin
                    step_q <= step_q + 1'b1;
                end else begin
                    step_q    <= '0;
                    instret_q <= instret_q + 1'b1;
                end
            end else if (e_rst) begin
                step_q    <= '0;
                instret_q <= instret_q + 1'b1;
            end else if (e_inc) begin
                // Running off the end of a row is a sequencing bug, not a wrap.
                if (step_q == SW'(STEPS - 1)) begin
                    step_q    <= '0;
                    illegal_q <= 1'b1;
                end else begin
                    step_q <= step_q + 1'b1;
                end
            end else begin
                step_q    <= '0;
                illegal_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ucode_sequencer.sv
// Scoreboard bench for ucode_sequencer: expectations are queued as stimulus
// is applied and drained against the DUT once outputs settle.
module tb_ucode_sequencer;

    localparam int OPW = 5;
    localparam int FW = 3;
    localparam int CW = 32;
    localparam int STEPS = 8;
    localparam int TIMEOUT = 4;
    localparam int CNT_W = 64;
    localparam int SW = 3;
    localparam int EW = 37;

    localparam int S_STEP = 0;
    localparam int S_CTRL = 1;
    localparam int S_STALL = 2;
    localparam int S_ILL = 3;
    localparam int S_TMO = 4;
    localparam int S_IR = 5;
    localparam int S_FETCH = 6;

    logic clk = 1'b0;
    logic reset;
    logic [OPW-1:0] opcode;
    logic [FW-1:0] func;
    logic ready;
    logic cond;
    logic trap;
    logic prog_en;
    logic prog_sel;
    logic [OPW-1:0] prog_row;
    logic [SW-1:0] prog_step;
    logic [EW-1:0] prog_data;
    logic [CW-1:0] ctrl;
    logic [SW-1:0] step;
    logic fetch;
    logic stall;
    logic illegal;
    logic timeout;
    logic [CNT_W-1:0] instret;

    ucode_sequencer #(
        .OPW(OPW), .FW(FW), .CW(CW), .STEPS(STEPS),
        .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .func(func),
        .ready(ready), .cond(cond), .trap(trap),
        .prog_en(prog_en), .prog_sel(prog_sel), .prog_row(prog_row),
        .prog_step(prog_step), .prog_data(prog_data),
        .ctrl(ctrl), .step(step), .fetch(fetch), .stall(stall),
        .illegal(illegal), .timeout(timeout), .instret(instret)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    logic [63:0] ir = 0;

    typedef struct {
        string tag;
        int sig;
        logic [63:0] val;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] probe(input int sig);
        case (sig)
            S_STEP:  return 64'(step);
            S_CTRL:  return 64'(ctrl);
            S_STALL: return 64'(stall);
            S_ILL:   return 64'(illegal);
            S_TMO:   return 64'(timeout);
            S_IR:    return instret;
            S_FETCH: return 64'(fetch);
            default: return '0;
        endcase
    endfunction

    task automatic want(input string tag, input int sig,
                        input logic [63:0] val);
        exp_t e;
        e.tag = tag;
        e.sig = sig;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic settle();
        exp_t e;
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.tag, probe(e.sig), e.val);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    function automatic logic [EW-1:0] mk(input bit inc, input bit rst,
                                         input bit cnd, input bit wt,
                                         input bit sub, input logic [31:0] c);
        return {sub, wt, cnd, rst, inc, c};
    endfunction

    task automatic prog(input bit sel, input int row, input int stp,
                        input logic [EW-1:0] d);
        prog_en = 1'b1;
        prog_sel = sel;
        prog_row = OPW'(row);
        prog_step = SW'(stp);
        prog_data = d;
        tick();
        prog_en = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        opcode = '0;
        func = '0;
        ready = 1'b0;
        cond = 1'b0;
        trap = 1'b0;
        prog_en = 1'b0;
        prog_sel = 1'b0;
        prog_row = '0;
        prog_step = '0;
        prog_data = '0;
        ticks(2);

        prog(0, 13, 0, mk(1, 0, 0, 1, 0, 32'h45));
        prog(0, 13, 1, mk(0, 1, 0, 0, 0, 32'h1));
        for (int i = 0; i < 3; i++)
            prog(0, 20, i, mk(1, 0, 0, 0, 0, 32'h100 + i));
        prog(0, 20, 3, mk(0, 0, 1, 0, 0, 32'h3));
        prog(0, 20, 4, mk(0, 1, 0, 0, 0, 32'h4));
        prog(0, 28, 0, mk(1, 0, 0, 0, 0, 32'h0));
        prog(0, 28, 1, mk(0, 0, 0, 0, 1, 32'h1000_0000));
        prog(1, 1, 1, mk(1, 0, 0, 0, 0, 32'h0180_0000));
        for (int i = 0; i < STEPS; i++)
            prog(0, 7, i, mk(1, 0, 0, 0, 0, 32'h700 + i));

        opcode = 5'd13;
        want("rst_ctrl", S_CTRL, 0);
        want("rst_step", S_STEP, 0);
        want("rst_fetch", S_FETCH, 1);
        want("rst_stall", S_STALL, 0);
        want("rst_ill", S_ILL, 0);
        want("rst_tmo", S_TMO, 0);
        want("rst_ir", S_IR, 0);
        settle();

        reset = 1'b0;
        ready = 1'b1;
        want("f_ctrl0", S_CTRL, 64'h45);
        want("f_stall0", S_STALL, 0);
        settle();
        tick();
        want("f_step1", S_STEP, 1);
        want("f_ctrl1", S_CTRL, 64'h1);
        want("f_fetch1", S_FETCH, 0);
        settle();
        tick();
        ir++;
        want("f_step2", S_STEP, 0);
        want("f_ir", S_IR, ir);
        settle();

        ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            want("w_stall", S_STALL, 1);
            want("w_step", S_STEP, 0);
            settle();
            tick();
        end
        ready = 1'b1;
        want("w_step_h", S_STEP, 0);
        want("w_stall_r", S_STALL, 0);
        want("w_tmo_n", S_TMO, 0);
        settle();
        tick();
        want("w_adv", S_STEP, 1);
        settle();
        tick();
        ir++;
        want("w_ir", S_IR, ir);
        settle();

        ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            want("t_pre_tmo", S_TMO, 0);
            want("t_pre_step", S_STEP, 0);
            settle();
        end
        tick();
        ready = 1'b1;
        want("t_tmo", S_TMO, 1);
        want("t_step", S_STEP, 0);
        want("t_ir", S_IR, ir);
        settle();
        tick();
        want("t_tmo_clr", S_TMO, 0);
        want("t_step1", S_STEP, 1);
        settle();
        tick();
        ir++;
        want("t_ir2", S_IR, ir);
        settle();

        ready = 1'b0;
        prog_en = 1'b1;
        prog_sel = 1'b0;
        prog_row = 5'd13;
        prog_step = '0;
        prog_data = mk(1, 0, 0, 1, 0, 32'h77);
        want("p_old", S_CTRL, 64'h45);
        settle();
        tick();
        prog_en = 1'b0;
        want("p_new", S_CTRL, 64'h77);
        want("p_step", S_STEP, 0);
        settle();
        ready = 1'b1;
        ticks(2);
        ir++;
        want("p_ir", S_IR, ir);
        settle();

        opcode = 5'd20;
        cond = 1'b1;
        ticks(3);
        want("c_step3", S_STEP, 3);
        want("c_ctrl3", S_CTRL, 64'h3);
        settle();
        tick();
        want("c_taken", S_STEP, 4);
        want("c_ctrl4", S_CTRL, 64'h4);
        settle();
        tick();
        ir++;
        want("c_ir1", S_IR, ir);
        settle();
        cond = 1'b0;
        ticks(4);
        ir++;
        want("c_nt_step", S_STEP, 0);
        want("c_nt_ir", S_IR, ir);
        settle();

        opcode = 5'd28;
        func = 3'd1;
        tick();
        want("s_ctrl", S_CTRL, 64'h1180_0000);
        settle();
        func = 3'd0;
        want("s_ctrl_f0", S_CTRL, 64'h1000_0000);
        settle();
        func = 3'd1;
        tick();
        want("s_step2", S_STEP, 2);
        want("s_ill0", S_ILL, 0);
        settle();
        tick();
        want("i_ill", S_ILL, 1);
        want("i_step", S_STEP, 0);
        want("i_ir", S_IR, ir);
        settle();
        tick();
        want("i_ill_clr", S_ILL, 0);
        settle();
        tick();
        trap = 1'b1;
        want("i_trap_ctrl", S_CTRL, 0);
        settle();
        tick();
        trap = 1'b0;
        want("i_trap_ill", S_ILL, 0);
        want("i_trap_step", S_STEP, 0);
        settle();

        opcode = 5'd7;
        ticks(7);
        want("e_step7", S_STEP, 7);
        want("e_ctrl7", S_CTRL, 64'h707);
        settle();
        tick();
        want("e_ill", S_ILL, 1);
        want("e_step0", S_STEP, 0);
        want("e_ir", S_IR, ir);
        settle();

        opcode = 5'd20;
        cond = 1'b1;
        ticks(3);
        trap = 1'b1;
        want("tr_ctrl", S_CTRL, 0);
        want("tr_step3", S_STEP, 3);
        settle();
        tick();
        trap = 1'b0;
        want("tr_step", S_STEP, 0);
        want("tr_ir", S_IR, ir);
        settle();

        opcode = 5'd13;
        ready = 1'b0;
        trap = 1'b1;
        want("tw_stall", S_STALL, 0);
        settle();
        ready = 1'b1;
        tick();
        trap = 1'b0;
        want("tw_step", S_STEP, 0);
        settle();

        opcode = 5'd20;
        ticks(2);
        want("r_step2", S_STEP, 2);
        settle();
        reset = 1'b1;
        tick();
        want("r_step", S_STEP, 0);
        want("r_ir", S_IR, 0);
        settle();
        reset = 1'b0;
        want("r_keep", S_CTRL, 64'h100);
        settle();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
